trade_stats: RTL

Downstream analytics stage fed directly by matching_engine. Consumes the per-cycle match flag, trade price and best bid/ask. Maintains running trade statistics: count, last, min, max, 8-trade moving average and spread. Keeps a circular trade-price history that the VGA renderer reads through a registered read port.

---
 rtl/trade_pkg.sv | 10 +
 rtl/trade_history_ram.sv | 29 ++
 rtl/trade_stats.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/trade_pkg.sv
// Shared sizing for the order-book analytics path; matching_engine imports
// the same PRICE_W so trade prices line up across both blocks.
package trade_pkg;
  localparam int PRICE_W    = 8;
  localparam int CNT_W      = 16;
  localparam int AVG_LOG2   = 3;
  localparam int HIST_DEPTH = 32;
  localparam int HIST_AW    = $clog2(HIST_DEPTH);
  localparam int SUM_W      = PRICE_W + AVG_LOG2;
endpackage

// File: rtl/trade_history_ram.sv
// Simple dual-port trade-price history: synchronous write, registered read,
// no reset so it maps onto block RAM.
module trade_history_ram #(
  parameter int DATA_W = trade_pkg::PRICE_W,
  parameter int DEPTH  = trade_pkg::HIST_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read returns the pre-write contents when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trade_stats.sv
// Running trade statistics (count, last, min, max, moving average, spread)
// plus a circular price history read back newest-first by the VGA renderer.
module trade_stats #(
  parameter int PRICE_W    = trade_pkg::PRICE_W,
  parameter int CNT_W      = trade_pkg::CNT_W,
  parameter int AVG_LOG2   = trade_pkg::AVG_LOG2,
  parameter int HIST_DEPTH = trade_pkg::HIST_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          match_valid,
  input  logic [PRICE_W-1:0]            trade_price,
  input  logic [PRICE_W-1:0]            best_bid,
  input  logic [PRICE_W-1:0]            best_ask,
  output logic [CNT_W-1:0]              trade_count,
  output logic [PRICE_W-1:0]            last_price,
  output logic [PRICE_W-1:0]            min_price,
  output logic [PRICE_W-1:0]            max_price,
  output logic [PRICE_W-1:0]            avg_price,
  output logic                          avg_valid,
  output logic [PRICE_W-1:0]            spread,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_addr,
  output logic [PRICE_W-1:0]            hist_rd_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_fill
);

  localparam int HIST_AW = $clog2(HIST_DEPTH);
  localparam int SUM_W   = PRICE_W + AVG_LOG2;
  localparam int AVG_WIN = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [HIST_AW:0]    FILL_MAX = (HIST_AW+1)'(HIST_DEPTH);
  localparam logic [AVG_LOG2:0]   WIN_MAX  = (AVG_LOG2+1)'(AVG_WIN);

  logic [CNT_W-1:0]   trade_count_q, trade_count_d;
  logic [PRICE_W-1:0] last_price_q, last_price_d;
  logic [PRICE_W-1:0] min_price_q, min_price_d;
  logic [PRICE_W-1:0] max_price_q, max_price_d;
  logic [PRICE_W-1:0] avg_price_q, avg_price_d;
  logic               avg_valid_q, avg_valid_d;
  logic [PRICE_W-1:0] spread_q, spread_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [PRICE_W-1:0] win_q [AVG_WIN];
  logic [PRICE_W-1:0] win_d [AVG_WIN];
  logic [AVG_LOG2:0]  win_fill_q, win_fill_d;
  logic [HIST_AW:0]   hist_fill_q, hist_fill_d;
  logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic               rd_zero_q, rd_zero_d;
  logic [HIST_AW-1:0] rd_phys_s;
  logic [PRICE_W-1:0] ram_rd_data_s;
  logic               wr_en_s;

  // Next-state for every statistic; a trade is any cycle with match_valid high.
  always_comb begin
    trade_count_d = trade_count_q;
    last_price_d  = last_price_q;
    min_price_d   = min_price_q;
    max_price_d   = max_price_q;
    sum_d         = sum_q;
    win_fill_d    = win_fill_q;
    hist_fill_d   = hist_fill_q;
    wr_ptr_d      = wr_ptr_q;
    for (int i = 0; i < AVG_WIN; i++) begin
      win_d[i] = win_q[i];
    end

    if (match_valid) begin
      trade_count_d = (trade_count_q == CNT_MAX) ? trade_count_q : trade_count_q + 1'b1;
      last_price_d  = trade_price;
      min_price_d   = (trade_price < min_price_q) ? trade_price : min_price_q;
      max_price_d   = (trade_price > max_price_q) ? trade_price : max_price_q;
      // Modular add/subtract is exact: the true sum never leaves SUM_W bits.
      sum_d         = sum_q + SUM_W'(trade_price) - SUM_W'(win_q[AVG_WIN-1]);
      win_d[0]      = trade_price;
      for (int i = 1; i < AVG_WIN; i++) begin
        win_d[i] = win_q[i-1];
      end
      win_fill_d    = (win_fill_q == WIN_MAX) ? win_fill_q : win_fill_q + 1'b1;
      hist_fill_d   = (hist_fill_q == FILL_MAX) ? hist_fill_q : hist_fill_q + 1'b1;
      wr_ptr_d      = wr_ptr_q + 1'b1;
    end else begin
      trade_count_d = trade_count_q;
    end

    avg_price_d = sum_d[SUM_W-1:AVG_LOG2];
    avg_valid_d = (win_fill_d == WIN_MAX);
    spread_d    = (best_ask >= best_bid) ? best_ask - best_bid : '0;

    // Newest entry sits just behind the write pointer as it stands this cycle.
    rd_phys_s   = wr_ptr_q - HIST_AW'(1) - hist_rd_addr;
    rd_zero_d   = ({1'b0, hist_rd_addr} >= hist_fill_q);
  end

  // State registers; reset overrides any trade presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      trade_count_q <= '0;
      last_price_q  <= '0;
      min_price_q   <= '1;
      max_price_q   <= '0;
      avg_price_q   <= '0;
      avg_valid_q   <= 1'b0;
      spread_q      <= '0;
      sum_q         <= '0;
      win_fill_q    <= '0;
      hist_fill_q   <= '0;
      wr_ptr_q      <= '0;
      rd_zero_q     <= 1'b1;
      for (int i = 0; i < AVG_WIN; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      trade_count_q <= trade_count_d;
      last_price_q  <= last_price_d;
      min_price_q   <= min_price_d;
      max_price_q   <= max_price_d;
      avg_price_q   <= avg_price_d;
      avg_valid_q   <= avg_valid_d;
      spread_q      <= spread_d;
      sum_q         <= sum_d;
      win_fill_q    <= win_fill_d;
      hist_fill_q   <= hist_fill_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_zero_q     <= rd_zero_d;
      for (int i = 0; i < AVG_WIN; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign wr_en_s = match_valid & ~reset;

  trade_history_ram #(
    .DATA_W (PRICE_W),
    .DEPTH  (HIST_DEPTH),
    .AW     (HIST_AW)
  ) u_hist (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_q),
    .wr_data (trade_price),
    .rd_addr (rd_phys_s),
    .rd_data (ram_rd_data_s)
  );

  assign trade_count  = trade_count_q;
  assign last_price   = last_price_q;
  assign min_price    = min_price_q;
  assign max_price    = max_price_q;
  assign avg_price    = avg_price_q;
  assign avg_valid    = avg_valid_q;
  assign spread       = spread_q;
  assign hist_fill    = hist_fill_q;
  // Stale RAM contents beyond the fill level are never exposed.
  assign hist_rd_data = rd_zero_q ? '0 : ram_rd_data_s;

endmodule
